mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_pmem_read  input  1  instruction-cache line read request.
REQ-005 i_pmem_write  input  1  instruction-cache line write request.
REQ-006 i_pmem_address  input  16  instruction-cache line address.
REQ-007 i_pmem_wdata  input  128  instruction-cache write line.
REQ-008 i_pmem_rdata  output  128  read line returned to instruction cache.
REQ-009 i_pmem_resp  output  1  instruction-cache transaction complete.
REQ-010 d_pmem_read  input  1  data-cache line read request.
REQ-011 d_pmem_write  input  1  data-cache line write (writeback) request.
REQ-012 d_pmem_address  input  16  data-cache line address.
REQ-013 d_pmem_wdata  input  128  data-cache write line.
REQ-014 d_pmem_rdata  output  128  read line returned to data cache.
REQ-015 d_pmem_resp  output  1  data-cache transaction complete.
REQ-016 pmem_read  output  1  physical memory read strobe.
REQ-017 pmem_write  output  1  physical memory write strobe.
REQ-018 pmem_address  output  16  physical memory line address.
REQ-019 pmem_wdata  output  128  physical memory write line.
REQ-020 pmem_rdata  input  128  physical memory read line.
REQ-021 pmem_resp  input  1  physical memory transaction complete, one-cycle pulse.

Function
REQ-022 Request per side: req_x = x_pmem_read | x_pmem_write.
REQ-023 FSM states: IDLE, GRANT_I, GRANT_D; one-bit register last_grant (I or D).
REQ-024 IDLE: pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0, both resp outputs 0.
REQ-025 IDLE transitions: only req_i -> GRANT_I; only req_d -> GRANT_D; both -> the side not equal to last_grant; neither -> stay IDLE.
REQ-026 Grant is registered: one cycle of arbitration latency from request in IDLE to pmem strobe.
REQ-027 GRANT_x: pmem_write = x_pmem_write, pmem_read = x_pmem_read & ~x_pmem_write, pmem_address/pmem_wdata = x inputs, combinationally.
REQ-028 GRANT_x: x_pmem_resp = pmem_resp; the other side's resp = 0 at all times.
REQ-029 i_pmem_rdata and d_pmem_rdata both equal pmem_rdata continuously; validity indicated only by the respective resp.
REQ-030 GRANT_x with pmem_resp = 1 -> IDLE next cycle, last_grant <= x; the mandatory IDLE cycle deasserts pmem strobes between transactions.
REQ-031 GRANT_x with req_x = 0 and pmem_resp = 0 (requester abandoned) -> IDLE next cycle; last_grant unchanged.
REQ-032 GRANT_x never switches to the other side while req_x holds and pmem_resp = 0; the other requester waits indefinitely.
REQ-033 pmem_resp received in IDLE is ignored: no resp output asserted, no state change.
REQ-034 Both sides continuously requesting -> strict alternation I, D, I, D, ...

Reset
REQ-035 rst = 1 at a clock edge -> state IDLE, last_grant = D, regardless of current state, including mid-transaction.
REQ-036 During and in the cycle after reset all pmem strobes and resp outputs = 0; a pmem_resp for an aborted transaction is ignored.
REQ-037 After reset with both requesting, instruction side is granted first.

Verification
REQ-038 Reset: rst high 2 cycles with i and d reading -> all strobes/resp 0; first post-reset cycle IDLE, second cycle pmem_read = 1, pmem_address = i_pmem_address.
REQ-039 Single read: i_pmem_read addr 0x1230, pmem_resp 3 cycles after strobe, pmem_rdata = 0xA5..A5 -> i_pmem_resp high exactly 1 cycle with i_pmem_rdata = 0xA5..A5; d_pmem_resp stays 0.
REQ-040 Contention: i read 0x0100 and d read 0x8000 held continuously -> pmem_address sequence 0x0100, 0x8000, 0x0100, 0x8000, with one strobe-low IDLE cycle between each.
REQ-041 Hold: d write 0x8040, wdata 0x1122..FF; i_pmem_read rises 1 cycle later -> pmem_write/address/wdata stay on d until pmem_resp; i granted on the following arbitration.
REQ-042 Abandon and abort: d drops request before pmem_resp -> IDLE next cycle, late pmem_resp produces no resp output; rst asserted mid-GRANT_I -> IDLE, strobes 0 next cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Cache-side and memory-side line buses of the two-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;

    // Instruction-cache side
    logic         i_pmem_read;
    logic         i_pmem_write;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_wdata;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;

    // Data-cache side
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;

    // Physical memory side
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    // Arbiter view
    modport slave (
        input  i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Environment view: caches and memory together
    modport master (
        output i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one physical memory port between
//               an instruction cache and a data cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
    input  wire logic   clk,
    input  wire logic   rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t state;
    logic   last_grant;

    logic req_i;
    logic req_d;

    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         resp_i;
    logic         resp_d;

    assign req_i = bus.i_pmem_read | bus.i_pmem_write;
    assign req_d = bus.d_pmem_read | bus.d_pmem_write;

    // A grant ends either on memory completion (which updates the fairness
    // pointer) or when its requester withdraws (which leaves it untouched).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SIDE_D;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && req_d) begin
                        state <= (last_grant == SIDE_I) ? GRANT_D : GRANT_I;
                    end else if (req_i) begin
                        state <= GRANT_I;
                    end else if (req_d) begin
                        state <= GRANT_D;
                    end
                end
                GRANT_I: begin
                    if (bus.pmem_resp) begin
                        state      <= IDLE;
                        last_grant <= SIDE_I;
                    end else if (!req_i) begin
                        state <= IDLE;
                    end
                end
                GRANT_D: begin
                    if (bus.pmem_resp) begin
                        state      <= IDLE;
                        last_grant <= SIDE_D;
                    end else if (!req_d) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Writes win over reads when a cache raises both strobes at once.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 16'h0000;
        mem_wdata   = 128'h0;
        resp_i      = 1'b0;
        resp_d      = 1'b0;
        case (state)
            GRANT_I: begin
                mem_write   = bus.i_pmem_write;
                mem_read    = bus.i_pmem_read & ~bus.i_pmem_write;
                mem_address = bus.i_pmem_address;
                mem_wdata   = bus.i_pmem_wdata;
                resp_i      = bus.pmem_resp;
            end
            GRANT_D: begin
                mem_write   = bus.d_pmem_write;
                mem_read    = bus.d_pmem_read & ~bus.d_pmem_write;
                mem_address = bus.d_pmem_address;
                mem_wdata   = bus.d_pmem_wdata;
                resp_d      = bus.pmem_resp;
            end
            default: begin
            end
        endcase
        // Reset silences the memory port even before the state register clears.
        if (rst) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_address = 16'h0000;
            mem_wdata   = 128'h0;
            resp_i      = 1'b0;
            resp_d      = 1'b0;
        end
    end

    assign bus.pmem_read    = mem_read;
    assign bus.pmem_write   = mem_write;
    assign bus.pmem_address = mem_address;
    assign bus.pmem_wdata   = mem_wdata;
    assign bus.i_pmem_resp  = resp_i;
    assign bus.d_pmem_resp  = resp_d;
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a port-ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: who currently owns the memory port and who was served last.
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    int m_owner = OWN_NONE;
    int m_last  = OWN_D;

    function automatic logic wants(input int side);
        if (side == OWN_I) return bus.i_pmem_read | bus.i_pmem_write;
        return bus.d_pmem_read | bus.d_pmem_write;
    endfunction

    function automatic int next_owner();
        if (rst) return OWN_NONE;
        if (m_owner == OWN_NONE) begin
            if (wants(OWN_I) && wants(OWN_D)) return (m_last == OWN_I) ? OWN_D : OWN_I;
            if (wants(OWN_I)) return OWN_I;
            if (wants(OWN_D)) return OWN_D;
            return OWN_NONE;
        end
        if (bus.pmem_resp || !wants(m_owner)) return OWN_NONE;
        return m_owner;
    endfunction

    function automatic int next_last();
        if (rst) return OWN_D;
        if (m_owner != OWN_NONE && bus.pmem_resp) return m_owner;
        return m_last;
    endfunction

    always @(posedge clk) begin
        m_owner <= next_owner();
        m_last  <= next_last();
    end

    function automatic logic exp_write();
        if (rst) return 1'b0;
        if (m_owner == OWN_I) return bus.i_pmem_write;
        if (m_owner == OWN_D) return bus.d_pmem_write;
        return 1'b0;
    endfunction

    function automatic logic exp_read();
        if (rst) return 1'b0;
        if (m_owner == OWN_I) return bus.i_pmem_read & ~bus.i_pmem_write;
        if (m_owner == OWN_D) return bus.d_pmem_read & ~bus.d_pmem_write;
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_addr();
        if (rst) return 16'h0;
        if (m_owner == OWN_I) return bus.i_pmem_address;
        if (m_owner == OWN_D) return bus.d_pmem_address;
        return 16'h0;
    endfunction

    function automatic logic [127:0] exp_wdata();
        if (rst) return 128'h0;
        if (m_owner == OWN_I) return bus.i_pmem_wdata;
        if (m_owner == OWN_D) return bus.d_pmem_wdata;
        return 128'h0;
    endfunction

    function automatic logic exp_resp(input int side);
        return !rst && (m_owner == side) && bus.pmem_resp;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_write   = 1'b0;
        bus.i_pmem_address = 16'h0;
        bus.i_pmem_wdata   = 128'h0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = 16'h0;
        bus.d_pmem_wdata   = 128'h0;
        bus.pmem_rdata     = 128'h0;
        bus.pmem_resp      = 1'b0;
    endtask

    task automatic quiesce();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        bus.i_pmem_read = 1'b1; bus.i_pmem_address = 16'h1111;
        bus.d_pmem_read = 1'b1; bus.d_pmem_address = 16'h2222;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.pmem_resp = (k == 1);
            @(negedge clk);
            checks++;
            if ({bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_quiet cyc%0d got rd/wr/ir/dr=%b want 0000", k,
                         {bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp});
            end
            tick();
        end
        rst = 1'b0;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.pmem_read, bus.i_pmem_resp, bus.d_pmem_resp} !== 3'b000) begin
            errors++;
            $display("FAIL reset_first_idle got rd/ir/dr=%b want 000",
                     {bus.pmem_read, bus.i_pmem_resp, bus.d_pmem_resp});
        end
        tick();
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h1111) begin
            errors++;
            $display("FAIL reset_i_first got rd=%b addr=%h want rd=1 addr=1111",
                     bus.pmem_read, bus.pmem_address);
        end
        tick();
        quiesce();
    endtask

    task automatic test_single_read();
        int resp_cycles = 0;
        quiesce();
        bus.pmem_rdata = {16{8'hA5}};
        for (int c = 0; c < 7; c++) begin
            bus.i_pmem_read    = (c < 5);
            bus.i_pmem_address = 16'h1230;
            bus.pmem_resp      = (c == 4);
            @(negedge clk);
            if (bus.i_pmem_resp === 1'b1) resp_cycles++;
            checks++;
            if (bus.d_pmem_resp !== 1'b0) begin
                errors++;
                $display("FAIL single_d_resp cyc%0d got %b want 0", c, bus.d_pmem_resp);
            end
            if (c == 0 || c >= 5) begin
                checks++;
                if (bus.pmem_read !== 1'b0) begin
                    errors++;
                    $display("FAIL single_idle_strobe cyc%0d got %b want 0", c, bus.pmem_read);
                end
            end else begin
                checks++;
                if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h1230) begin
                    errors++;
                    $display("FAIL single_strobe cyc%0d got rd=%b addr=%h want rd=1 addr=1230",
                             c, bus.pmem_read, bus.pmem_address);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.i_pmem_resp !== 1'b1 || bus.i_pmem_rdata !== {16{8'hA5}}) begin
                    errors++;
                    $display("FAIL single_resp got resp=%b rdata=%h want 1 a5..a5",
                             bus.i_pmem_resp, bus.i_pmem_rdata);
                end
            end
            tick();
        end
        checks++;
        if (resp_cycles != 1) begin
            errors++;
            $display("FAIL single_resp_width got %0d cycles want 1", resp_cycles);
        end
    endtask

    task automatic test_contention();
        logic [15:0] seq [$];
        logic [15:0] want [4];
        int run = 0;
        int low = 0;
        logic prev_resp = 1'b0;
        want[0] = 16'h0100; want[1] = 16'h8000; want[2] = 16'h0100; want[3] = 16'h8000;
        quiesce();
        bus.i_pmem_read = 1'b1; bus.i_pmem_address = 16'h0100;
        bus.d_pmem_read = 1'b1; bus.d_pmem_address = 16'h8000;
        for (int c = 0; c < 60 && seq.size() < 4; c++) begin
            bus.pmem_resp = (run >= 2);
            @(negedge clk);
            if (prev_resp) begin
                checks++;
                if (bus.pmem_read !== 1'b0) begin
                    errors++;
                    $display("FAIL contention_gap cyc%0d got rd=%b want 0", c, bus.pmem_read);
                end
            end
            if (bus.pmem_read === 1'b1) begin
                if (run == 0) begin
                    seq.push_back(bus.pmem_address);
                    if (seq.size() > 1) begin
                        checks++;
                        if (low != 1) begin
                            errors++;
                            $display("FAIL contention_low_cycles got %0d want 1", low);
                        end
                    end
                end
                run++;
                low = 0;
            end else begin
                run = 0;
                low++;
            end
            if (bus.pmem_resp) run = 0;
            prev_resp = bus.pmem_resp;
            tick();
        end
        checks++;
        if (seq.size() != 4) begin
            errors++;
            $display("FAIL contention_budget got %0d grants want 4", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seq[k] !== want[k]) begin
                    errors++;
                    $display("FAIL contention_order[%0d] got %h want %h", k, seq[k], want[k]);
                end
            end
        end
        quiesce();
    endtask

    task automatic test_hold();
        logic [127:0] w = 128'h11223344556677889900AABBCCDDEEFF;
        quiesce();
        for (int c = 0; c < 10; c++) begin
            bus.d_pmem_write   = (c < 7);
            bus.d_pmem_address = 16'h8040;
            bus.d_pmem_wdata   = w;
            bus.i_pmem_read    = (c >= 1 && c < 10);
            bus.i_pmem_address = 16'h4444;
            bus.pmem_resp      = (c == 6 || c == 9);
            @(negedge clk);
            if (c >= 1 && c <= 6) begin
                checks++;
                if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 ||
                    bus.pmem_address !== 16'h8040 || bus.pmem_wdata !== w || bus.i_pmem_resp !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_d cyc%0d got wr=%b rd=%b addr=%h ir=%b want wr=1 rd=0 addr=8040 ir=0",
                             c, bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.i_pmem_resp);
                end
            end
            if (c == 6) begin
                checks++;
                if (bus.d_pmem_resp !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_d_resp got %b want 1", bus.d_pmem_resp);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_idle got rd=%b wr=%b want 0 0", bus.pmem_read, bus.pmem_write);
                end
            end
            if (c >= 8) begin
                checks++;
                if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h4444 ||
                    bus.i_pmem_resp !== (c == 9)) begin
                    errors++;
                    $display("FAIL hold_i_after cyc%0d got rd=%b addr=%h ir=%b want rd=1 addr=4444",
                             c, bus.pmem_read, bus.pmem_address, bus.i_pmem_resp);
                end
            end
            tick();
        end
        quiesce();
    endtask

    task automatic test_abandon();
        quiesce();
        for (int c = 0; c < 5; c++) begin
            bus.d_pmem_read    = (c < 2);
            bus.d_pmem_address = 16'h0ABC;
            bus.pmem_resp      = (c == 3);
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0ABC) begin
                    errors++;
                    $display("FAIL abandon_grant got rd=%b addr=%h want 1 0abc", bus.pmem_read, bus.pmem_address);
                end
            end
            if (c >= 2) begin
                checks++;
                if ({bus.pmem_read, bus.d_pmem_resp, bus.i_pmem_resp} !== 3'b000) begin
                    errors++;
                    $display("FAIL abandon_quiet cyc%0d got rd/dr/ir=%b want 000",
                             c, {bus.pmem_read, bus.d_pmem_resp, bus.i_pmem_resp});
                end
            end
            tick();
        end
        // An abandoned I grant must not count as I having been served.
        quiesce();
        bus.i_pmem_read = 1'b1; bus.i_pmem_address = 16'h5555;
        tick();
        tick();
        bus.i_pmem_read = 1'b0;
        tick();
        bus.i_pmem_read = 1'b1;
        bus.d_pmem_read = 1'b1; bus.d_pmem_address = 16'h6666;
        tick();
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h5555) begin
            errors++;
            $display("FAIL abandon_pointer got rd=%b addr=%h want 1 5555", bus.pmem_read, bus.pmem_address);
        end
        tick();
        quiesce();
    endtask

    task automatic test_abort();
        quiesce();
        bus.i_pmem_read = 1'b1; bus.i_pmem_address = 16'h3210;
        tick();
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3210) begin
            errors++;
            $display("FAIL abort_grant got rd=%b addr=%h want 1 3210", bus.pmem_read, bus.pmem_address);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h0) begin
            errors++;
            $display("FAIL abort_during got rd=%b addr=%h want 0 0000", bus.pmem_read, bus.pmem_address);
        end
        tick();
        rst = 1'b0;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.i_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got rd=%b ir=%b want 0 0", bus.pmem_read, bus.i_pmem_resp);
        end
        tick();
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL abort_regrant got rd=%b want 1", bus.pmem_read);
        end
        tick();
        quiesce();
    endtask

    task automatic test_random();
        logic ireq = 1'b0;
        logic dreq = 1'b0;
        logic idone = 1'b0;
        logic ddone = 1'b0;
        int   kind;
        quiesce();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!ireq && $urandom_range(0, 2) == 0) begin
                ireq = 1'b1;
                kind = $urandom_range(0, 3);
                bus.i_pmem_read    = (kind != 1);
                bus.i_pmem_write   = (kind >= 1 && kind <= 2);
                bus.i_pmem_address = 16'($urandom);
                bus.i_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end else if (ireq && (idone || $urandom_range(0, 39) == 0)) begin
                ireq = 1'b0;
                bus.i_pmem_read  = 1'b0;
                bus.i_pmem_write = 1'b0;
            end
            if (!dreq && $urandom_range(0, 2) == 0) begin
                dreq = 1'b1;
                kind = $urandom_range(0, 3);
                bus.d_pmem_read    = (kind != 1);
                bus.d_pmem_write   = (kind >= 1 && kind <= 2);
                bus.d_pmem_address = 16'($urandom);
                bus.d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end else if (dreq && (ddone || $urandom_range(0, 39) == 0)) begin
                dreq = 1'b0;
                bus.d_pmem_read  = 1'b0;
                bus.d_pmem_write = 1'b0;
            end
            bus.pmem_resp  = ($urandom_range(0, 3) == 0);
            bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            checks++;
            if (bus.pmem_read !== exp_read() || bus.pmem_write !== exp_write()) begin
                errors++;
                $display("FAIL rand_strobe cyc%0d got rd=%b wr=%b want rd=%b wr=%b",
                         c, bus.pmem_read, bus.pmem_write, exp_read(), exp_write());
            end
            checks++;
            if (bus.pmem_address !== exp_addr() || bus.pmem_wdata !== exp_wdata()) begin
                errors++;
                $display("FAIL rand_addr_data cyc%0d got addr=%h wdata=%h want addr=%h wdata=%h",
                         c, bus.pmem_address, bus.pmem_wdata, exp_addr(), exp_wdata());
            end
            checks++;
            if (bus.i_pmem_resp !== exp_resp(OWN_I) || bus.d_pmem_resp !== exp_resp(OWN_D)) begin
                errors++;
                $display("FAIL rand_resp cyc%0d got ir=%b dr=%b want ir=%b dr=%b",
                         c, bus.i_pmem_resp, bus.d_pmem_resp, exp_resp(OWN_I), exp_resp(OWN_D));
            end
            checks++;
            if (bus.i_pmem_rdata !== bus.pmem_rdata || bus.d_pmem_rdata !== bus.pmem_rdata) begin
                errors++;
                $display("FAIL rand_rdata cyc%0d got i=%h d=%h want %h",
                         c, bus.i_pmem_rdata, bus.d_pmem_rdata, bus.pmem_rdata);
            end
            idone = exp_resp(OWN_I);
            ddone = exp_resp(OWN_D);
            tick();
        end
        quiesce();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_contention();
        test_hold();
        test_abandon();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
